// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter widths and the sync-decoder state encoding.
package vga_timing_pkg;

   localparam int unsigned H_PW_DEF        = 96;
   localparam int unsigned H_BP_DEF        = 48;
   localparam int unsigned H_DISP_DEF      = 640;
   localparam int unsigned H_FP_DEF        = 16;
   localparam int unsigned V_PW_DEF        = 2;
   localparam int unsigned V_BP_DEF        = 33;
   localparam int unsigned V_DISP_DEF      = 480;
   localparam int unsigned V_FP_DEF        = 10;
   localparam int unsigned LOCK_FRAMES_DEF = 2;

   localparam int unsigned CNT_W  = 11;
   localparam int unsigned POS_W  = 12;
   localparam int unsigned GOOD_W = 3;

   function automatic int unsigned timing_total(input int unsigned pw, input int unsigned bp,
                                                input int unsigned disp, input int unsigned fp);
      return pw + bp + disp + fp;
   endfunction

   localparam int unsigned H_S_DEF = timing_total(H_PW_DEF, H_BP_DEF, H_DISP_DEF, H_FP_DEF);
   localparam int unsigned V_S_DEF = timing_total(V_PW_DEF, V_BP_DEF, V_DISP_DEF, V_FP_DEF);

   // Counters stick at all-ones so a dead input cannot wrap back into a valid-looking position.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } sync_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop for an active-low sync, advanced on pix_en.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic pix_en,
   input  logic sync_n,
   output logic fall_c,
   output logic rise_c
);

   logic meta;
   logic sync;
   logic prev;

   // Idle level is high so reset never manufactures a fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else if (pix_en) begin
         meta <= sync_n;
         sync <= meta;
         prev <= sync;
      end
   end

   assign fall_c = prev & ~sync;
   assign rise_c = ~prev & sync;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers VGA pixel position from hsync/vsync, qualifies timing and reports lock.
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_PW        = H_PW_DEF,
   parameter int unsigned H_BP        = H_BP_DEF,
   parameter int unsigned H_DISP      = H_DISP_DEF,
   parameter int unsigned H_FP        = H_FP_DEF,
   parameter int unsigned V_PW        = V_PW_DEF,
   parameter int unsigned V_BP        = V_BP_DEF,
   parameter int unsigned V_DISP      = V_DISP_DEF,
   parameter int unsigned V_FP        = V_FP_DEF,
   parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_en,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [POS_W-1:0] x,
   output logic [POS_W-1:0] y,
   output logic             de,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] line_len,
   output logic [CNT_W-1:0] frame_lines
);

   localparam int unsigned H_S = timing_total(H_PW, H_BP, H_DISP, H_FP);
   localparam int unsigned V_S = timing_total(V_PW, V_BP, V_DISP, V_FP);

   localparam logic [CNT_W-1:0]  H_PW_C  = CNT_W'(H_PW);
   localparam logic [CNT_W-1:0]  H_LAST  = CNT_W'(H_S - 1);
   localparam logic [CNT_W-1:0]  H_OVER  = CNT_W'(H_S);
   localparam logic [CNT_W-1:0]  V_LAST  = CNT_W'(V_S - 1);
   localparam logic [CNT_W-1:0]  V_OVER  = CNT_W'(V_S);
   localparam logic [POS_W-1:0]  X_OFS   = POS_W'(H_PW + H_BP);
   localparam logic [POS_W-1:0]  Y_OFS   = POS_W'(V_PW + V_BP);
   localparam logic [POS_W-1:0]  X_RST   = POS_W'(0) - X_OFS;
   localparam logic [POS_W-1:0]  Y_RST   = POS_W'(0) - Y_OFS;
   localparam logic [POS_W-1:0]  X_ACT   = POS_W'(H_DISP);
   localparam logic [POS_W-1:0]  Y_ACT   = POS_W'(V_DISP);
   localparam logic [GOOD_W-1:0] LOCK_N  = GOOD_W'(LOCK_FRAMES);

   logic h_fall;
   logic h_rise;
   logic v_fall;
   logic v_rise_unused;

   sync_edge_det u_hsync (
      .clk    (clk),
      .rst    (rst),
      .pix_en (pix_en),
      .sync_n (hsync_in),
      .fall_c (h_fall),
      .rise_c (h_rise)
   );

   sync_edge_det u_vsync (
      .clk    (clk),
      .rst    (rst),
      .pix_en (pix_en),
      .sync_n (vsync_in),
      .fall_c (v_fall),
      .rise_c (v_rise_unused)
   );

   sync_state_e       state;
   sync_state_e       state_nxt;
   logic [GOOD_W-1:0] good_cnt;
   logic [GOOD_W-1:0] good_cnt_nxt;
   logic              err_nxt;

   logic [CNT_W-1:0]  cnt_x;
   logic [CNT_W-1:0]  cnt_y;
   logic [CNT_W-1:0]  cnt_x_nxt;
   logic [CNT_W-1:0]  cnt_y_nxt;
   logic              rise_ok;
   logic              frame_ok;
   logic [POS_W-1:0]  x_nxt;
   logic [POS_W-1:0]  y_nxt;
   logic              de_nxt;

   logic              rise_pos_c;
   logic              good_line_c;
   logic              good_frame_c;
   logic              viol_c;

   // Counter recovery: fall restarts, vsync fall wins over the line increment.
   always_comb begin
      cnt_x_nxt = sat_inc(cnt_x);
      if (h_fall) begin
         cnt_x_nxt = '0;
      end
      cnt_y_nxt = cnt_y;
      if (v_fall) begin
         cnt_y_nxt = '0;
      end else if (h_fall) begin
         cnt_y_nxt = sat_inc(cnt_y);
      end
   end

   // Rise is judged by the count it lands on, i.e. the pulse width in pixels.
   assign rise_pos_c   = (sat_inc(cnt_x) == H_PW_C);
   assign good_line_c  = h_fall && (cnt_x == H_LAST) && rise_ok;
   assign good_frame_c = v_fall && good_line_c && (cnt_y == V_LAST) && frame_ok;

   assign viol_c = (h_rise && !rise_pos_c)
                || (h_fall && (cnt_x != H_LAST))
                || (!h_fall && (cnt_x == H_OVER))
                || (v_fall && !h_fall)
                || (!v_fall && (cnt_y == V_OVER));

   always_comb begin
      state_nxt    = state;
      good_cnt_nxt = good_cnt;
      err_nxt      = 1'b0;
      unique case (state)
         SEARCH: begin
            if (v_fall) begin
               state_nxt    = ALIGN;
               good_cnt_nxt = '0;
            end
         end
         ALIGN: begin
            if (v_fall) begin
               if (good_frame_c && !viol_c) begin
                  good_cnt_nxt = good_cnt + GOOD_W'(1);
                  if (good_cnt_nxt >= LOCK_N) begin
                     state_nxt = LOCKED;
                  end
               end else begin
                  good_cnt_nxt = '0;
               end
            end
         end
         LOCKED: begin
            if (viol_c) begin
               err_nxt      = 1'b1;
               state_nxt    = SEARCH;
               good_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt    = SEARCH;
            good_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= SEARCH;
         good_cnt <= '0;
      end else if (pix_en) begin
         state    <= state_nxt;
         good_cnt <= good_cnt_nxt;
      end
   end

   // Outputs track the post-tick counter values so x/y stay aligned with cnt_x/cnt_y.
   always_comb begin
      x_nxt  = POS_W'(cnt_x_nxt) - X_OFS;
      y_nxt  = POS_W'(cnt_y_nxt) - Y_OFS;
      de_nxt = (state_nxt == LOCKED) && (x_nxt < X_ACT) && (y_nxt < Y_ACT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_x       <= '0;
         cnt_y       <= '0;
         rise_ok     <= 1'b0;
         frame_ok    <= 1'b0;
         line_len    <= '0;
         frame_lines <= '0;
         x           <= X_RST;
         y           <= Y_RST;
         de          <= 1'b0;
         locked      <= 1'b0;
         err         <= 1'b0;
      end else if (pix_en) begin
         cnt_x <= cnt_x_nxt;
         cnt_y <= cnt_y_nxt;
         if (h_fall) begin
            line_len <= sat_inc(cnt_x);
            rise_ok  <= 1'b0;
         end else if (h_rise) begin
            rise_ok <= rise_pos_c;
         end
         if (v_fall) begin
            frame_lines <= sat_inc(cnt_y);
            frame_ok    <= 1'b1;
         end else if (h_fall) begin
            frame_ok <= frame_ok & good_line_c;
         end
         x      <= x_nxt;
         y      <= y_nxt;
         de     <= de_nxt;
         locked <= (state_nxt == LOCKED);
         err    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 17x10 timing, plus a default-timing reset check.
module tb_vga_sync_decoder;

   localparam int HS = 17;
   localparam int VS = 10;
   localparam int FR = HS * VS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, pix_en, hsync_in, vsync_in;
   logic [11:0] x, y, dx, dy;
   logic        de, locked, err, dde, dlocked, derr;
   logic [10:0] line_len, frame_lines, dll, dfl;

   vga_sync_decoder #(
      .H_PW(4), .H_BP(3), .H_DISP(8), .H_FP(2),
      .V_PW(2), .V_BP(2), .V_DISP(4), .V_FP(2), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .x(x), .y(y), .de(de), .locked(locked), .err(err),
      .line_len(line_len), .frame_lines(frame_lines)
   );

   vga_sync_decoder dut_def (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .x(dx), .y(dy), .de(dde), .locked(dlocked), .err(derr),
      .line_len(dll), .frame_lines(dfl)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int          tick_no = 0, err_cnt = 0, last_err_idx = -1, de_cnt = 0, lock_cnt = 0, de_oob = 0;
   logic [10:0] ll_at_err;
   logic [11:0] de_fx, de_fy, de_lx, de_ly;
   bit          de_first;
   int          g_x = 0, g_y = 0, h_len = HS, h_pw = 4, v_lines = VS;

   // One pixel tick: drive syncs, strobe pix_en for one clock, sample at the following negedge.
   task automatic px(input logic h, input logic v);
      hsync_in = h;
      vsync_in = v;
      repeat (3) @(negedge clk);
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      if (err) begin
         err_cnt++;
         last_err_idx = tick_no;
         ll_at_err = line_len;
      end
      if (locked) lock_cnt++;
      if (de) begin
         de_cnt++;
         if (!de_first) begin
            de_first = 1'b1;
            de_fx = x;
            de_fy = y;
         end
         de_lx = x;
         de_ly = y;
         if (x >= 12'd8 || y >= 12'd4) de_oob++;
      end
      tick_no++;
   endtask

   task automatic gen(input int n);
      for (int i = 0; i < n; i++) begin
         px((g_x < h_pw) ? 1'b0 : 1'b1, (g_y < 2) ? 1'b0 : 1'b1);
         g_x++;
         if (g_x >= h_len) begin
            g_x = 0;
            g_y++;
            if (g_y >= v_lines) g_y = 0;
         end
      end
   endtask

   task automatic to_frame_start();
      while (g_x != 0 || g_y != 0) gen(1);
   endtask

   task automatic to_line_start();
      while (g_x != 0) gen(1);
   endtask

   task automatic clear_stats();
      err_cnt = 0; de_cnt = 0; lock_cnt = 0; de_oob = 0; de_first = 1'b0; last_err_idx = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (x !== 12'd4089) begin n_bad++; $display("FAIL rst_x: got %0d want 4089", x); end
      n_cmp++; if (y !== 12'd4092) begin n_bad++; $display("FAIL rst_y: got %0d want 4092", y); end
      n_cmp++; if ({de, locked, err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {de, locked, err}); end
      n_cmp++; if ({line_len, frame_lines} !== 22'd0) begin n_bad++; $display("FAIL rst_len: got %0d/%0d want 0/0", line_len, frame_lines); end
      n_cmp++; if (dx !== 12'd3952) begin n_bad++; $display("FAIL rst_def_x: got %0d want 3952", dx); end
      n_cmp++; if (dy !== 12'd4061) begin n_bad++; $display("FAIL rst_def_y: got %0d want 4061", dy); end
      n_cmp++; if ({dde, dlocked, derr, dll, dfl} !== 25'd0) begin n_bad++; $display("FAIL rst_def_rest: got %0h want 0", {dde, dlocked, derr, dll, dfl}); end
      rst = 1'b0;
   endtask

   task automatic test_lock();
      clear_stats();
      g_x = 0; g_y = 0;
      gen(2 * FR + 2);
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b want 0", locked); end
      gen(1);
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_frame2: got %b want 1", locked); end
      clear_stats();
      gen(FR);
      n_cmp++; if (de_cnt !== 32) begin n_bad++; $display("FAIL de_count: got %0d want 32", de_cnt); end
      n_cmp++; if (de_oob !== 0) begin n_bad++; $display("FAIL de_range: got %0d want 0", de_oob); end
      n_cmp++; if ({de_fx, de_fy} !== {12'd0, 12'd0}) begin n_bad++; $display("FAIL de_first: got %0d,%0d want 0,0", de_fx, de_fy); end
      n_cmp++; if ({de_lx, de_ly} !== {12'd7, 12'd3}) begin n_bad++; $display("FAIL de_last: got %0d,%0d want 7,3", de_lx, de_ly); end
      n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL nominal_err: got %0d want 0", err_cnt); end
      n_cmp++; if (lock_cnt !== FR) begin n_bad++; $display("FAIL lock_hold: got %0d want %0d", lock_cnt, FR); end
      n_cmp++; if (line_len !== 11'd17) begin n_bad++; $display("FAIL line_len: got %0d want 17", line_len); end
      n_cmp++; if (frame_lines !== 11'd10) begin n_bad++; $display("FAIL frame_lines: got %0d want 10", frame_lines); end
   endtask

   task automatic test_long_line();
      int l0;
      to_frame_start();
      gen(5 * HS);
      clear_stats();
      l0 = tick_no;
      h_len = HS + 1;
      gen(HS + 1);
      h_len = HS;
      gen(3);
      n_cmp++; if (last_err_idx !== l0 + 20) begin n_bad++; $display("FAIL long_err_tick: got %0d want %0d", last_err_idx, l0 + 20); end
      n_cmp++; if (ll_at_err !== 11'd18) begin n_bad++; $display("FAIL long_line_len: got %0d want 18", ll_at_err); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL long_unlock: got %b want 0", locked); end
      to_frame_start();
      gen(2 * FR + 2);
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %b want 0", locked); end
      gen(1);
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relock: got %b want 1", locked); end
      n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL long_err_once: got %0d want 1", err_cnt); end
   endtask

   task automatic test_hsync_stuck();
      int l0;
      to_line_start();
      gen(2 * HS);
      clear_stats();
      l0 = tick_no;
      for (int i = 0; i < 2100; i++) px((i < 4) ? 1'b0 : 1'b1, 1'b1);
      n_cmp++; if (last_err_idx !== l0 + 20) begin n_bad++; $display("FAIL stuck_err_tick: got %0d want %0d", last_err_idx, l0 + 20); end
      n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL stuck_err_once: got %0d want 1", err_cnt); end
      n_cmp++; if (x !== 12'd2040) begin n_bad++; $display("FAIL stuck_sat_x: got %0d want 2040", x); end
      n_cmp++; if ({locked, de} !== 2'b00) begin n_bad++; $display("FAIL stuck_unlock: got %b want 00", {locked, de}); end
      g_x = 0; g_y = 0;
   endtask

   task automatic test_short_frames();
      clear_stats();
      v_lines = VS - 1;
      gen(5 * HS * (VS - 1));
      v_lines = VS;
      n_cmp++; if (lock_cnt !== 0) begin n_bad++; $display("FAIL short_frame_lock: got %0d want 0", lock_cnt); end
      n_cmp++; if (de_cnt !== 0) begin n_bad++; $display("FAIL short_frame_de: got %0d want 0", de_cnt); end
      n_cmp++; if (frame_lines !== 11'd9) begin n_bad++; $display("FAIL short_frame_lines: got %0d want 9", frame_lines); end
      n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL short_frame_err: got %0d want 0", err_cnt); end
   endtask

   task automatic test_short_pulse();
      int l0;
      to_frame_start();
      clear_stats();
      h_pw = 3;
      gen(4 * FR);
      h_pw = 4;
      n_cmp++; if ({lock_cnt, err_cnt} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL pw_prelock: got lock %0d err %0d want 0 0", lock_cnt, err_cnt); end
      gen(2 * FR + 3);
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL pw_relock: got %b want 1", locked); end
      to_line_start();
      gen(2 * HS);
      clear_stats();
      l0 = tick_no;
      h_pw = 3;
      gen(HS);
      h_pw = 4;
      n_cmp++; if (last_err_idx !== l0 + 5) begin n_bad++; $display("FAIL pw_err_tick: got %0d want %0d", last_err_idx, l0 + 5); end
      to_frame_start();
      n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL pw_err_once: got %0d want 1", err_cnt); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL pw_unlock: got %b want 0", locked); end
   endtask

   task automatic test_async_reset();
      gen(2 * FR + 3);
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL pre_rst_lock: got %b want 1", locked); end
      gen(95);
      n_cmp++; if ({x, y, de} !== {12'd3, 12'd1, 1'b1}) begin n_bad++; $display("FAIL mid_xy: got x %0d y %0d de %b want 3 1 1", x, y, de); end
      #3 rst = 1'b1;
      #1;
      n_cmp++; if ({locked, de, err} !== 3'b000) begin n_bad++; $display("FAIL arst_flags: got %b want 000", {locked, de, err}); end
      n_cmp++; if ({x, y} !== {12'd4089, 12'd4092}) begin n_bad++; $display("FAIL arst_xy: got %0d,%0d want 4089,4092", x, y); end
      n_cmp++; if ({dx, dy} !== {12'd3952, 12'd4061}) begin n_bad++; $display("FAIL arst_def_xy: got %0d,%0d want 3952,4061", dx, dy); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      g_x = 0; g_y = 0;
      gen(2 * FR + 2);
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL arst_relock_early: got %b want 0", locked); end
      gen(1);
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL arst_relock: got %b want 1", locked); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_long_line();
      test_hsync_stuck();
      test_short_frames();
      test_short_pulse();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
